// File: rtl/stopwatch_ctrl.sv
// Stopwatch front-end control: synchronises and debounces the two push-buttons,
// runs the IDLE/RUN/PAUSE machine and generates the count tick and counter clear
// that drive the downstream timing counter.
`timescale 1ns/1ps
module stopwatch_ctrl #(
  parameter int unsigned DIV    = 5000000,
  parameter int unsigned DB_LEN = 500000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       btn_ss,
  input  logic       btn_rst,
  output logic       en,
  output logic       cnt_clr,
  output logic       running,
  output logic [1:0] state
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned DW = (DB_LEN > 1) ? $clog2(DB_LEN) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  localparam logic [DW-1:0] DB_LAST  = DW'(DB_LEN - 1);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;

  // Bit 0 is start/stop, bit 1 is reset.
  logic [1:0]         sync1_q, sync2_q;
  logic [1:0]         db_q, db_d;
  logic [1:0]         db_dly_q;
  logic [1:0][DW-1:0] dbcnt_q, dbcnt_d;
  logic [1:0]         press;
  logic               ss_p, rs_p;

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          en_q, en_d;
  logic          cnt_clr_q, cnt_clr_d;
  logic          running_q;

  // Two-flop synchronisers for the raw buttons.
  always_ff @(posedge clk) begin
    if (clr) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {btn_rst, btn_ss};
      sync2_q <= sync1_q;
    end
  end

  // Debounce: level flips only after DB_LEN consecutive differing samples.
  always_comb begin
    db_d    = db_q;
    dbcnt_d = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != db_q[i]) begin
        if (dbcnt_q[i] == DB_LAST) begin
          db_d[i]    = ~db_q[i];
          dbcnt_d[i] = '0;
        end else begin
          dbcnt_d[i] = dbcnt_q[i] + DW'(1);
        end
      end
    end
  end

  // Debounced levels, their counters and the edge-detect delay flops.
  always_ff @(posedge clk) begin
    if (clr) begin
      db_q     <= '0;
      dbcnt_q  <= '0;
      db_dly_q <= '0;
    end else begin
      db_q     <= db_d;
      dbcnt_q  <= dbcnt_d;
      db_dly_q <= db_q;
    end
  end

  assign press = db_q & ~db_dly_q;
  assign ss_p  = press[0];
  assign rs_p  = press[1];

  // Next state and clear pulse; reset press wins over start/stop.
  always_comb begin
    state_d   = state_q;
    cnt_clr_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rs_p) begin
          cnt_clr_d = 1'b1;
        end else if (ss_p) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (ss_p) begin
          state_d = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (rs_p) begin
          state_d   = S_IDLE;
          cnt_clr_d = 1'b1;
        end else if (ss_p) begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d   = S_IDLE;
        cnt_clr_d = 1'b1;
      end
    endcase
  end

  // Prescaler: free-runs in RUN, holds in PAUSE so a partial tick survives.
  always_comb begin
    en_d = (state_q == S_RUN) && (presc_q == PRE_LAST);
    case (state_q)
      S_RUN:   presc_d = (presc_q == PRE_LAST) ? '0 : presc_q + PW'(1);
      S_PAUSE: presc_d = presc_q;
      default: presc_d = '0;
    endcase
  end

  // State, prescaler and registered outputs.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= S_IDLE;
      presc_q   <= '0;
      en_q      <= 1'b0;
      cnt_clr_q <= 1'b1;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      en_q      <= en_d;
      cnt_clr_q <= cnt_clr_d;
      running_q <= (state_d == S_RUN);
    end
  end

  assign en      = en_q;
  assign cnt_clr = cnt_clr_q;
  assign running = running_q;
  assign state   = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DIV=4, DB_LEN=3, 100 ns clock.
// Inputs change and outputs are sampled on the falling edge.
`timescale 1ns/1ps
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       clr;
  logic       btn_ss;
  logic       btn_rst;
  logic       en;
  logic       cnt_clr;
  logic       running;
  logic [1:0] state;

  int vectors     = 0;
  int miscompares = 0;

  stopwatch_ctrl #(.DIV(4), .DB_LEN(3)) dut (
    .clk     (clk),
    .clr     (clr),
    .btn_ss  (btn_ss),
    .btn_rst (btn_rst),
    .en      (en),
    .cnt_clr (cnt_clr),
    .running (running),
    .state   (state)
  );

  always #50 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish, expected finish before 1 ms");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // From IDLE: start press reaches RUN 6 edges after the raw edge, first tick 4 later.
  task automatic do_start(input string tag);
    btn_ss = 1'b1;
    step(5);
    chk({tag, "_pre_state"}, 32'(state), 32'(2'b00));
    step(1);
    chk({tag, "_run_state"}, 32'(state), 32'(2'b01));
    chk({tag, "_running"}, 32'(running), 32'(1'b1));
    step(1);
    chk({tag, "_en_early1"}, 32'(en), 32'(1'b0));
    step(2);
    chk({tag, "_en_early3"}, 32'(en), 32'(1'b0));
    step(1);
    chk({tag, "_first_en"}, 32'(en), 32'(1'b1));
    btn_ss = 1'b0;
    step(1);
    chk({tag, "_en_width"}, 32'(en), 32'(1'b0));
    step(8);
  endtask

  // Reset press (optionally with start/stop on the same edge) from a given state.
  task automatic rs_check(input string tag, input logic [1:0] pre, input logic with_ss);
    btn_rst = 1'b1;
    btn_ss  = with_ss;
    step(5);
    chk({tag, "_pre_state"}, 32'(state), 32'(pre));
    chk({tag, "_pre_clr"}, 32'(cnt_clr), 32'(1'b0));
    step(1);
    chk({tag, "_state"}, 32'(state), 32'(2'b00));
    chk({tag, "_clr_pulse"}, 32'(cnt_clr), 32'(1'b1));
    chk({tag, "_running"}, 32'(running), 32'(1'b0));
    step(1);
    chk({tag, "_clr_end"}, 32'(cnt_clr), 32'(1'b0));
    chk({tag, "_state_hold"}, 32'(state), 32'(2'b00));
    btn_rst = 1'b0;
    btn_ss  = 1'b0;
    step(8);
  endtask

  initial begin
    int   n_en, gap_err, clr_err, prev;
    logic found;

    clr = 1'b1; btn_ss = 1'b0; btn_rst = 1'b0;

    // Reset for two edges.
    step(1);
    chk("rst_clr_edge1", 32'(cnt_clr), 32'(1'b1));
    step(1);
    chk("rst_state", 32'(state), 32'(2'b00));
    chk("rst_en", 32'(en), 32'(1'b0));
    chk("rst_running", 32'(running), 32'(1'b0));
    chk("rst_clr_edge2", 32'(cnt_clr), 32'(1'b1));
    clr = 1'b0;
    step(1);
    chk("rst_clr_drop", 32'(cnt_clr), 32'(1'b0));
    chk("rst_state_after", 32'(state), 32'(2'b00));
    step(4);

    // Start, then 620 ticks spaced exactly 4 clocks.
    do_start("start");
    n_en = 0; gap_err = 0; clr_err = 0; prev = -1;
    for (int c = 0; c < 2480; c++) begin
      step(1);
      if (en) begin
        if (prev >= 0 && (c - prev) != 4) gap_err++;
        prev = c;
        n_en++;
      end
      if (cnt_clr) clr_err++;
    end
    chk("tick_count", 32'(n_en), 32'd620);
    chk("tick_spacing", 32'(gap_err), 32'd0);
    chk("tick_no_clr", 32'(clr_err), 32'd0);

    // Reset press is ignored in RUN.
    btn_rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1);
      chk("rs_run_state", 32'(state), 32'(2'b01));
      chk("rs_run_clr", 32'(cnt_clr), 32'(1'b0));
    end
    btn_rst = 1'b0;
    step(8);

    // Pause with the prescaler at 2, then resume: tick 2 clocks after RUN.
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      step(1);
      if (en) found = 1'b1;
    end
    chk("pause_align", 32'(found), 32'(1'b1));
    btn_ss = 1'b1;
    step(4);
    chk("pause_last_en", 32'(en), 32'(1'b1));
    step(1);
    chk("pause_pre_state", 32'(state), 32'(2'b01));
    step(1);
    chk("pause_state", 32'(state), 32'(2'b10));
    chk("pause_running", 32'(running), 32'(1'b0));
    step(4);
    btn_ss = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("pause_no_en", 32'(en), 32'(1'b0));
      chk("pause_hold", 32'(state), 32'(2'b10));
    end
    btn_ss = 1'b1;
    step(6);
    chk("resume_state", 32'(state), 32'(2'b01));
    step(1);
    chk("resume_en1", 32'(en), 32'(1'b0));
    step(1);
    chk("resume_en2", 32'(en), 32'(1'b1));
    step(1);
    chk("resume_en3", 32'(en), 32'(1'b0));
    btn_ss = 1'b0;
    step(3);
    chk("resume_en6", 32'(en), 32'(1'b1));
    step(8);

    // Back to PAUSE, then reset press returns to IDLE with a clear pulse.
    btn_ss = 1'b1;
    step(6);
    chk("pause2_state", 32'(state), 32'(2'b10));
    step(2);
    btn_ss = 1'b0;
    step(8);
    rs_check("rs_pause", 2'b10, 1'b0);

    // Reset press in IDLE.
    rs_check("rs_idle", 2'b00, 1'b0);

    // Two-clock glitches never reach the state machine.
    for (int r = 0; r < 5; r++) begin
      btn_ss = 1'b1;
      step(2);
      btn_ss = 1'b0;
      for (int i = 0; i < 5; i++) begin
        step(1);
        chk("glitch_state", 32'(state), 32'(2'b00));
        chk("glitch_en", 32'(en), 32'(1'b0));
      end
    end
    step(4);

    // Simultaneous presses in IDLE: reset wins.
    rs_check("both_idle", 2'b00, 1'b1);

    // Simultaneous presses in PAUSE: reset wins.
    do_start("start2");
    btn_ss = 1'b1;
    step(6);
    chk("pause3_state", 32'(state), 32'(2'b10));
    step(2);
    btn_ss = 1'b0;
    step(8);
    rs_check("both_pause", 2'b10, 1'b1);

    // Synchronous clear in the middle of RUN.
    do_start("start3");
    step(3);
    clr = 1'b1;
    step(1);
    chk("midrun_state", 32'(state), 32'(2'b00));
    chk("midrun_en", 32'(en), 32'(1'b0));
    chk("midrun_running", 32'(running), 32'(1'b0));
    chk("midrun_clr", 32'(cnt_clr), 32'(1'b1));
    clr = 1'b0;
    step(1);
    chk("midrun_clr_drop", 32'(cnt_clr), 32'(1'b0));
    for (int i = 0; i < 6; i++) begin
      step(1);
      chk("midrun_idle_en", 32'(en), 32'(1'b0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Front-end control stage that sits directly upstream of the stopwatch counter `timing`.
- Takes two raw push-buttons (start/stop, reset), then synchronises and debounces them.
- Runs the IDLE/RUN/PAUSE state machine.
- Produces the one-cycle count-enable tick (`en`) and the counter clear (`cnt_clr`) that drive `timing`'s `en` and `clr` inputs.

Parameters:
- DIV, 5000000: clk cycles per count tick (0.1 s at 50 MHz); legal range ≥2.
- DB_LEN, 500000: consecutive stable synchronised cycles required to accept a button level change; legal range ≥2.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- clr  in  1  reset; synchronous, active-high.
- btn_ss  in  1  raw start/stop button, asynchronous, active-high.
- btn_rst  in  1  raw reset button, asynchronous, active-high.
- en  out  1  count tick to `timing`; high for exactly one clk per tick period.
- cnt_clr  out  1  clear to `timing`, active-high.
- running  out  1  high while state = RUN.
- state  out  2  IDLE=00, RUN=01, PAUSE=10; 11 is unused.

Behaviour:
- Reset (clr=1 at an edge):
  - state=IDLE, en=0, running=0, cnt_clr=1.
  - Prescaler, debounce counters, synchroniser flops, debounced levels and edge-detect flops all cleared to 0.
  - Reset overrides everything, including a reset asserted mid-RUN.
  - cnt_clr is a registered output: it is 1 on the edge where clr is sampled high, and returns to 0 on the first edge with clr=0 unless a reset press is accepted.
- Input synchroniser: two-flop synchroniser per button.
- Debounce, per button:
  - Counter increments while the synchronised value differs from the debounced level, and resets to 0 whenever they are equal.
  - When the counter reaches DB_LEN-1 and the values still differ, the debounced level toggles on that edge and the counter returns to 0.
  - Glitches shorter than DB_LEN cycles are never seen.
- Press pulse: registered rising-edge detect of the debounced level, giving one cycle per press; release edges are ignored.
- Latency: a clean raw 0→1 held steady changes state DB_LEN+3 to DB_LEN+4 clocks after the raw edge (±1 for asynchronous sampling).
- FSM transitions (ss = start/stop press pulse, rs = reset press pulse):
  - IDLE: ss and not rs → RUN; rs → stay IDLE and pulse cnt_clr.
  - RUN: ss → PAUSE; rs is ignored, because reset is not allowed while running.
  - PAUSE: rs → IDLE and pulse cnt_clr (rs beats ss when both arrive in the same cycle); ss alone → RUN.
  - The unused encoding 11 → IDLE on the next edge with a cnt_clr pulse.
- cnt_clr pulse: high for exactly one cycle, the edge after rs is accepted; coincident with the state register update.
- Prescaler (width clog2(DIV)):
  - IDLE: forced to 0.
  - RUN: counts 0..DIV-1 and wraps to 0.
  - PAUSE: holds its value, so a partial tick is preserved across pause/resume.
- en:
  - Registered; en=1 in the cycle following an edge where state=RUN and prescaler=DIV-1.
  - Never high in IDLE or PAUSE. If ss moves RUN→PAUSE on the same edge as the terminal count, that final en still fires once.
  - Spacing is exactly DIV clocks while RUN is continuous.
- Timing from IDLE→RUN: the first en comes DIV clocks after the edge that sets state=RUN.
- running = (state==RUN), registered with state.

Test Plan (DIV=4, DB_LEN=3, clk period 100 ns):
- Reset: clr=1 for 2 edges, then 0 → state=00, en=0, running=0; cnt_clr=1 during reset, 0 on the first edge after clr drops.
- Start and tick:
  - Stimulus: after reset, btn_ss=1 held for 10 clocks.
  - Response: state=01 within 6–7 clocks of the raw edge; en pulses exactly 1 cycle wide, every 4 clocks.
  - Across 620 ticks, the count of en pulses equals 620.
- Glitch rejection:
  - Stimulus: btn_ss high for 2 clocks, then low; repeat 5 times.
  - Response: state stays 00, en never asserted.
- Pause/resume preserves phase:
  - Stimulus: in RUN, press ss when the prescaler is at 2 (state→10), hold PAUSE 20 clocks, press ss again.
  - Response: no en during PAUSE; first en arrives 2 clocks after state returns to 01.
- Reset rules:
  - rs in RUN → state stays 01, cnt_clr stays 0.
  - rs in PAUSE → state=00 with cnt_clr high for exactly 1 cycle; prescaler reads 0.
  - rs in IDLE → cnt_clr 1-cycle pulse, state stays 00.
- Simultaneous presses:
  - btn_ss and btn_rst raised on the same edge while in PAUSE → state=00, cnt_clr pulse.
  - Same stimulus in IDLE → state stays 00, cnt_clr pulse.
  - Sync clr asserted mid-RUN → state=00, en=0 on the next edge.
